// File: rtl/jtframe_pxl_reduce.sv
// Colour-depth reducer: narrows wi-bit RGB components to wo bits, with 2x2 ordered dither.
// Latency: 2 cen cycles on rgb_out, hs_out, vs_out, lhbl_out and lvbl_out.
// Backpressure: none; every register advances only on cen and holds while cen=0.
//
// Optional feature macro: JTFRAME_DITHER_EN
//   defined   -> 2x2 ordered dither, phase alternated each frame (col/row/frame counters)
//   undefined -> round to nearest, no phase counters
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cen                 pixel clock enable
//   hs, vs              sync inputs
//   lhbl, lvbl          blanking inputs, active low (1 = active pixel/line)
//   rgb_in  [3*wi]      {r,g,b} wide colour
//   rgb_out [3*wo]      {r,g,b} reduced colour, forced to 0 during blanking
//   hs_out, vs_out,
//   lhbl_out, lvbl_out  sync/blanking delayed to stay aligned with rgb_out
module jtframe_pxl_reduce #(
  parameter int wi = 8,
  parameter int wo = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  input  logic            hs,
  input  logic            vs,
  input  logic            lhbl,
  input  logic            lvbl,
  input  logic [3*wi-1:0] rgb_in,
  output logic [3*wo-1:0] rgb_out,
  output logic            hs_out,
  output logic            vs_out,
  output logic            lhbl_out,
  output logic            lvbl_out
);

  localparam int d = wi - wo;

  // Stage 1 registers
  logic [3*wi-1:0] s1_rgb;
  logic            s1_hs;
  logic            s1_vs;
  logic            s1_lhbl;
  logic            s1_lvbl;

  // Offset added to every component before truncation (d bits wide)
  logic [d-1:0] offset;

`ifdef JTFRAME_DITHER_EN
  logic       col;
  logic       row;
  logic       frame;
  logic       lhbl_l;
  logic       lvbl_l;
  logic [1:0] s1_idx;

  // Bayer 2x2 value scaled to the dropped bits: (B * 2^d) >> 2.
  // B <= 3, so B << d fits in d+2 bits and the result fits in d bits.
  function automatic logic [d-1:0] bayer_off(input logic [1:0] idx);
    logic [d+1:0] b;
    logic [d+1:0] scaled;
    b = '0;
    case (idx)
      2'b00:   b[1:0] = 2'd0;
      2'b01:   b[1:0] = 2'd2;
      2'b10:   b[1:0] = 2'd3;
      default: b[1:0] = 2'd1;
    endcase
    scaled = (b << d) >> 2;
    return scaled[d-1:0];
  endfunction

  // Phase counters. Edges are detected against the lhbl/lvbl seen on the previous cen.
  // On a simultaneous lhbl/lvbl fall the row clear takes priority over the toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col    <= 1'b0;
      row    <= 1'b0;
      frame  <= 1'b0;
      lhbl_l <= 1'b0;
      lvbl_l <= 1'b0;
      s1_idx <= 2'b00;
    end else if (cen) begin
      lhbl_l <= lhbl;
      lvbl_l <= lvbl;
      col    <= lhbl ? ~col : 1'b0;
      if (!lvbl)
        row <= 1'b0;
      else if (lhbl_l && !lhbl)
        row <= ~row;
      if (lvbl_l && !lvbl)
        frame <= ~frame;
      // Index uses the counter values that belong to the pixel being captured
      s1_idx <= {row ^ frame, col};
    end
  end

  always_comb begin
    offset = bayer_off(s1_idx);
  end
`else
  // Round to nearest: half of the weight of the dropped bits
  always_comb begin
    offset        = '0;
    offset[d-1]   = 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_rgb  <= '0;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_lhbl <= 1'b0;
      s1_lvbl <= 1'b0;
    end else if (cen) begin
      s1_rgb  <= rgb_in;
      s1_hs   <= hs;
      s1_vs   <= vs;
      s1_lhbl <= lhbl;
      s1_lvbl <= lvbl;
    end
  end

  // Per-component add, saturate on carry-out, keep the top wo bits
  logic [3*wo-1:0] reduced;

  for (genvar i = 0; i < 3; i++) begin : g_comp
    logic [wi:0] sum;
    logic        unused_lsb;

    assign sum        = {1'b0, s1_rgb[i*wi +: wi]} + {{(wi+1-d){1'b0}}, offset};
    assign unused_lsb = ^sum[d-1:0];
    assign reduced[i*wo +: wo] = sum[wi] ? {wo{1'b1}} : sum[wi-1:d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_out  <= '0;
      hs_out   <= 1'b0;
      vs_out   <= 1'b0;
      lhbl_out <= 1'b0;
      lvbl_out <= 1'b0;
    end else if (cen) begin
      rgb_out  <= (s1_lhbl && s1_lvbl) ? reduced : '0;
      hs_out   <= s1_hs;
      vs_out   <= s1_vs;
      lhbl_out <= s1_lhbl;
      lvbl_out <= s1_lvbl;
    end
  end

endmodule

// File: tb/tb_jtframe_pxl_reduce.sv
// Bench for jtframe_pxl_reduce (wi=8, wo=5): directed steps, expected outputs queued
// when each pixel is driven and compared two cen cycles later.
// Expectations follow JTFRAME_DITHER_EN the same way the design does.
module tb_jtframe_pxl_reduce;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cen;
  logic        hs;
  logic        vs;
  logic        lhbl;
  logic        lvbl;
  logic [23:0] rgb_in;
  logic [14:0] rgb_out;
  logic        hs_out;
  logic        vs_out;
  logic        lhbl_out;
  logic        lvbl_out;

  jtframe_pxl_reduce #(.wi(8), .wo(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .hs       (hs),
    .vs       (vs),
    .lhbl     (lhbl),
    .lvbl     (lvbl),
    .rgb_in   (rgb_in),
    .rgb_out  (rgb_out),
    .hs_out   (hs_out),
    .vs_out   (vs_out),
    .lhbl_out (lhbl_out),
    .lvbl_out (lvbl_out)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Scoreboard: {hs,vs,lhbl,lvbl,rgb[14:0]}
  logic [18:0] exp_q[$];
  string       tag_q[$];
  logic [18:0] last_exp = '0;

  // Reference phase state
  bit m_col, m_row, m_frame, m_lhbl_l, m_lvbl_l;
  bit vs_cur = 1'b0;

  function automatic logic [4:0] red8(input logic [7:0] v, input logic [1:0] idx);
    logic [8:0] s;
    logic [2:0] off;
`ifdef JTFRAME_DITHER_EN
    case (idx)
      2'd0:    off = 3'd0;
      2'd1:    off = 3'd4;
      2'd2:    off = 3'd6;
      default: off = 3'd2;
    endcase
`else
    off = 3'd4;
`endif
    s = {1'b0, v} + {6'd0, off};
    return s[8] ? 5'h1F : s[7:3];
  endfunction

  task automatic check(input logic [18:0] expv, input string tag);
    logic [18:0] obs;
    obs = {hs_out, vs_out, lhbl_out, lvbl_out, rgb_out};
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_col = 0; m_row = 0; m_frame = 0; m_lhbl_l = 0; m_lvbl_l = 0;
    exp_q.delete();
    tag_q.delete();
    last_exp = '0;
  endtask

  // One cen cycle of stimulus; compares the entry pushed on the previous cen
  task automatic step(input bit h, input bit v, input bit hb, input bit vb,
                      input logic [23:0] px, input string tag);
    logic [1:0]  idx;
    logic [14:0] e_rgb;
    hs = h; vs = v; lhbl = hb; lvbl = vb; rgb_in = px; cen = 1'b1;
    @(posedge clk);
    idx   = {m_row ^ m_frame, m_col};
    e_rgb = (hb && vb) ? {red8(px[23:16], idx), red8(px[15:8], idx), red8(px[7:0], idx)} : 15'd0;
    exp_q.push_back({h, v, hb, vb, e_rgb});
    tag_q.push_back(tag);
    if (!vb)
      m_row = 0;
    else if (m_lhbl_l && !hb)
      m_row = ~m_row;
    if (m_lvbl_l && !vb)
      m_frame = ~m_frame;
    m_col    = hb ? ~m_col : 1'b0;
    m_lhbl_l = hb;
    m_lvbl_l = vb;
    #1;
    if (exp_q.size() > 1) begin
      last_exp = exp_q.pop_front();
      check(last_exp, tag_q.pop_front());
    end
  endtask

  // Active pixels followed by a short horizontal blank with all-ones colour
  task automatic line(input int n, input logic [23:0] px, input bit vb, input string tag);
    for (int i = 0; i < n; i++)
      step(1'b0, vs_cur, 1'b1, vb, px, tag);
    for (int i = 0; i < 4; i++)
      step(i == 1 || i == 2, vs_cur, 1'b0, vb, 24'hFFFFFF, "hblank");
  endtask

  task automatic line_rand(input int n, input bit vb, input string tag);
    for (int i = 0; i < n; i++)
      step(1'b0, vs_cur, 1'b1, vb, 24'($urandom), tag);
    for (int i = 0; i < 4; i++)
      step(i == 1 || i == 2, vs_cur, 1'b0, vb, 24'($urandom), "hblank_rand");
  endtask

  task automatic vblank();
    line(6, 24'hFFFFFF, 1'b0, "vblank");
    vs_cur = 1'b1;
    line(6, 24'hFFFFFF, 1'b0, "vblank_vs");
    vs_cur = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cen = 1'b1; hs = 0; vs = 0; lhbl = 0; lvbl = 0; rgb_in = '0;
    model_reset();
    @(posedge clk);
    #1;
    check(19'd0, "reset_init");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Latency: single bright pixel, hs marker travels with it
    step(1'b1, 1'b0, 1'b1, 1'b1, 24'hF80000, "lat_f8");
    step(1'b0, 1'b0, 1'b1, 1'b1, 24'h000000, "lat_next");
    n_assert++;
    assert (rgb_out[14:10] === 5'h1F && hs_out === 1'b1) else begin
      n_fail++;
      $error("FAIL lat_direct: observed r=%h hs=%b expected r=1f hs=1", rgb_out[14:10], hs_out);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 24'h000000, "lat_tail");
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 1'b0, 1'b1, 24'hFFFFFF, "blank_ones");

    // Dither pattern over two lines of a constant colour
    line(8, 24'h131313, 1'b1, "dither_l0");
    line(8, 24'h131313, 1'b1, "dither_l1");

    // Frame boundary, then the same lines with swapped row phase
    vblank();
    line(8, 24'h131313, 1'b1, "dither_f1_l0");
    line(8, 24'h131313, 1'b1, "dither_f1_l1");

    // Saturation near full scale
    line(6, 24'hFEFEFE, 1'b1, "sat_fe_l0");
    line(6, 24'hFEFEFE, 1'b1, "sat_fe_l1");
    line(6, 24'hFDFDFD, 1'b1, "sat_fd");

    // Outputs hold while cen is low
    step(1'b0, 1'b0, 1'b1, 1'b1, 24'h40A0F0, "pre_hold_a");
    step(1'b1, 1'b0, 1'b1, 1'b1, 24'h80C010, "pre_hold_b");
    cen = 1'b0;
    rgb_in = 24'hFFFFFF; hs = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check(last_exp, "cen_hold");
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 24'h102030, "post_hold");

    // Random content across a frame change
    for (int i = 0; i < 3; i++)
      line_rand(7, 1'b1, "rand_f1");
    vblank();
    for (int i = 0; i < 3; i++)
      line_rand(7, 1'b1, "rand_f0");

    // Flush the last pending entry
    step(1'b0, 1'b0, 1'b0, 1'b1, 24'h0, "flush");

    // Asynchronous reset mid-line: outputs clear without a clock edge
    step(1'b1, 1'b1, 1'b1, 1'b1, 24'hFFFFFF, "pre_rst_a");
    step(1'b1, 1'b1, 1'b1, 1'b1, 24'hFFFFFF, "pre_rst_b");
    #1;
    rst_n = 1'b0;
    #1;
    check(19'd0, "reset_async");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    line(5, 24'h131313, 1'b1, "after_rst");
    line_rand(5, 1'b1, "after_rst_rand");
    step(1'b0, 1'b0, 1'b0, 1'b1, 24'h0, "flush2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
